// File: rtl/pipe_skid_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_skid_stage_pkg
//  Description : Shared state encodings and widths for the elastic pipeline
//                stage and the performance counters attached to it.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_skid_stage_pkg;

    // Occupancy-coded states: the state code is also the number of beats held.
    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_FULL  = 2'd2
    } pipe_state_e;

    localparam int C_OCC_W = 2;

    // Ready is the registered complement of "next state is FULL".
    function automatic logic ready_for(input pipe_state_e nxt);
        return (nxt != PS_FULL);
    endfunction

endpackage : pipe_skid_stage_pkg
`default_nettype wire

// File: rtl/pipe_skid_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_skid_stage_if
//  Description : Valid/ready handshake bundle between two pipeline stages,
//                plus flush control and debug observability.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_skid_stage_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) ();

    logic             flush_i;
    logic             up_valid_i;
    logic             up_ready_o;
    logic [WIDTH-1:0] up_data_i;
    logic             dn_valid_o;
    logic             dn_ready_i;
    logic [WIDTH-1:0] dn_data_o;
    logic [1:0]       occupancy_o;
    logic [CNT_W-1:0] stall_cnt_o;

    // View from inside the stage
    modport slave (
        input  flush_i, up_valid_i, up_data_i, dn_ready_i,
        output up_ready_o, dn_valid_o, dn_data_o, occupancy_o, stall_cnt_o
    );

    // View from the surrounding pipeline (drives upstream, consumes downstream)
    modport master (
        output flush_i, up_valid_i, up_data_i, dn_ready_i,
        input  up_ready_o, dn_valid_o, dn_data_o, occupancy_o, stall_cnt_o
    );

endinterface : pipe_skid_stage_if
`default_nettype wire

// File: rtl/pipe_skid_stage_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Saturating up-counter for performance-debug event counts.
//                Sticks at all-ones; cleared only by reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  wire logic             clk_i,
    input  wire logic             rst_n,
    input  wire logic             inc_i,
    output logic      [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] r_cnt;

    // Count events until the counter is all-ones, then hold.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (inc_i && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt_o = r_cnt;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_skid_stage
//  Description : Elastic pipeline stage, main register plus 1-entry skid
//                register, so the upstream ready is fully registered.
//                Synchronous flush and saturating stall-cycle counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_stage
    import pipe_skid_stage_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  wire logic          clk_i,
    input  wire logic          rst_n,
    pipe_skid_stage_if.slave   bus
);

    pipe_state_e      r_state;
    logic             r_up_ready;
    logic             r_dn_valid;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;

    logic             w_up_xfer;
    logic             w_dn_xfer;
    logic             w_stall;

    assign w_up_xfer = bus.up_valid_i & r_up_ready;
    assign w_dn_xfer = r_dn_valid & bus.dn_ready_i;
    assign w_stall   = r_dn_valid & ~bus.dn_ready_i;

    // Occupancy FSM with registered ready/valid; main always holds the oldest beat.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= PS_EMPTY;
            r_up_ready <= 1'b1;
            r_dn_valid <= 1'b0;
            r_main     <= '0;
            r_skid     <= '0;
        end else if (bus.flush_i) begin
            // Held and incoming beats are dropped; data registers keep their contents.
            r_state    <= PS_EMPTY;
            r_up_ready <= ready_for(PS_EMPTY);
            r_dn_valid <= 1'b0;
        end else begin
            case (r_state)
                PS_EMPTY: begin
                    if (w_up_xfer) begin
                        r_main     <= bus.up_data_i;
                        r_state    <= PS_ONE;
                        r_dn_valid <= 1'b1;
                    end
                    r_up_ready <= 1'b1;
                end
                PS_ONE: begin
                    if (w_up_xfer && w_dn_xfer) begin
                        r_main     <= bus.up_data_i;
                        r_up_ready <= ready_for(PS_ONE);
                    end else if (w_up_xfer) begin
                        // Downstream stalled: park the new beat behind main.
                        r_skid     <= bus.up_data_i;
                        r_state    <= PS_FULL;
                        r_up_ready <= ready_for(PS_FULL);
                    end else if (w_dn_xfer) begin
                        r_state    <= PS_EMPTY;
                        r_dn_valid <= 1'b0;
                        r_up_ready <= ready_for(PS_EMPTY);
                    end
                end
                PS_FULL: begin
                    if (w_dn_xfer) begin
                        r_main     <= r_skid;
                        r_state    <= PS_ONE;
                        r_up_ready <= ready_for(PS_ONE);
                    end
                end
                default: begin
                    // Unused code 2'd3 falls back to an empty stage.
                    r_state    <= PS_EMPTY;
                    r_dn_valid <= 1'b0;
                    r_up_ready <= 1'b1;
                end
            endcase
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .inc_i (w_stall),
        .cnt_o (bus.stall_cnt_o)
    );

    assign bus.up_ready_o  = r_up_ready;
    assign bus.dn_valid_o  = r_dn_valid;
    assign bus.dn_data_o   = r_main;
    assign bus.occupancy_o = r_state;

endmodule : pipe_skid_stage
`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_skid_stage
//  Description : Directed and randomized checks of the elastic pipeline stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_stage;

    logic clk;
    logic rst_n;
    int   vectors;
    int   errors;

    pipe_skid_stage_if #(.WIDTH(32), .CNT_W(16)) b1 ();
    pipe_skid_stage_if #(.WIDTH(32), .CNT_W(4))  b2 ();

    pipe_skid_stage #(.WIDTH(32), .CNT_W(16)) u_dut (
        .clk_i (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    pipe_skid_stage #(.WIDTH(32), .CNT_W(4)) u_dut_sat (
        .clk_i (clk),
        .rst_n (rst_n),
        .bus   (b2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        b1.flush_i    = 1'b0;
        b1.up_valid_i = 1'b0;
        b1.up_data_i  = '0;
        b1.dn_ready_i = 1'b0;
        b2.flush_i    = 1'b0;
        b2.up_valid_i = 1'b0;
        b2.up_data_i  = '0;
        b2.dn_ready_i = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        b1.flush_i    = 1'b0;
        b1.up_valid_i = 1'b1;
        b1.up_data_i  = 32'hDEAD_BEEF;
        b1.dn_ready_i = 1'b0;
        tick();
        tick();
        vectors++;
        if (b1.dn_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", b1.dn_valid_o); end
        vectors++;
        if (b1.up_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", b1.up_ready_o); end
        vectors++;
        if (b1.occupancy_o !== 2'd0) begin errors++; $display("FAIL reset_occ got %0d want 0", b1.occupancy_o); end
        vectors++;
        if (b1.stall_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_stall got %0d want 0", b1.stall_cnt_o); end
        vectors++;
        if (b1.dn_data_o !== 32'd0) begin errors++; $display("FAIL reset_data got %h want 0", b1.dn_data_o); end
        rst_n = 1'b1;
        tick();
        vectors++;
        if (b1.dn_valid_o !== 1'b1 || b1.dn_data_o !== 32'hDEAD_BEEF || b1.occupancy_o !== 2'd1) begin
            errors++;
            $display("FAIL reset_first_beat got v=%0b d=%h occ=%0d want v=1 d=deadbeef occ=1",
                     b1.dn_valid_o, b1.dn_data_o, b1.occupancy_o);
        end
        b1.up_valid_i = 1'b0;
    endtask

    task automatic test_streaming();
        do_reset();
        b1.dn_ready_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            b1.up_valid_i = 1'b1;
            b1.up_data_i  = 32'(i);
            tick();
            vectors++;
            if (b1.dn_valid_o !== 1'b1 || b1.dn_data_o !== 32'(i) || b1.occupancy_o !== 2'd1 || b1.up_ready_o !== 1'b1) begin
                errors++;
                $display("FAIL stream_beat%0d got v=%0b d=%0d occ=%0d rdy=%0b want v=1 d=%0d occ=1 rdy=1",
                         i, b1.dn_valid_o, b1.dn_data_o, b1.occupancy_o, b1.up_ready_o, i);
            end
        end
        b1.up_valid_i = 1'b0;
        tick();
        vectors++;
        if (b1.dn_valid_o !== 1'b0 || b1.occupancy_o !== 2'd0) begin
            errors++;
            $display("FAIL stream_drain got v=%0b occ=%0d want v=0 occ=0", b1.dn_valid_o, b1.occupancy_o);
        end
        vectors++;
        if (b1.stall_cnt_o !== 16'd0) begin errors++; $display("FAIL stream_stall got %0d want 0", b1.stall_cnt_o); end
    endtask

    task automatic test_backpressure();
        do_reset();
        b1.dn_ready_i = 1'b0;
        b1.up_valid_i = 1'b1;
        b1.up_data_i  = 32'hAAAA_0001;
        tick();
        b1.up_data_i  = 32'hBBBB_0002;
        tick();
        b1.up_valid_i = 1'b0;
        vectors++;
        if (b1.occupancy_o !== 2'd2 || b1.up_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_full got occ=%0d rdy=%0b want occ=2 rdy=0", b1.occupancy_o, b1.up_ready_o);
        end
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (b1.dn_data_o !== 32'hAAAA_0001 || b1.dn_valid_o !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold%0d got v=%0b d=%h want v=1 d=aaaa0001", k, b1.dn_valid_o, b1.dn_data_o);
            end
            if (k < 4) tick();
        end
        vectors++;
        if (b1.stall_cnt_o !== 16'd5) begin errors++; $display("FAIL bp_stall got %0d want 5", b1.stall_cnt_o); end
        b1.dn_ready_i = 1'b1;
        tick();
        vectors++;
        if (b1.dn_data_o !== 32'hBBBB_0002 || b1.dn_valid_o !== 1'b1 || b1.up_ready_o !== 1'b1 || b1.occupancy_o !== 2'd1) begin
            errors++;
            $display("FAIL bp_second got v=%0b d=%h rdy=%0b occ=%0d want v=1 d=bbbb0002 rdy=1 occ=1",
                     b1.dn_valid_o, b1.dn_data_o, b1.up_ready_o, b1.occupancy_o);
        end
        tick();
        vectors++;
        if (b1.dn_valid_o !== 1'b0 || b1.occupancy_o !== 2'd0 || b1.stall_cnt_o !== 16'd5) begin
            errors++;
            $display("FAIL bp_drain got v=%0b occ=%0d stall=%0d want v=0 occ=0 stall=5",
                     b1.dn_valid_o, b1.occupancy_o, b1.stall_cnt_o);
        end
    endtask

    task automatic test_flush();
        do_reset();
        b1.dn_ready_i = 1'b0;
        b1.up_valid_i = 1'b1;
        b1.up_data_i  = 32'hA;
        tick();
        b1.up_data_i  = 32'hB;
        tick();
        vectors++;
        if (b1.occupancy_o !== 2'd2) begin errors++; $display("FAIL flush_prefull got occ=%0d want 2", b1.occupancy_o); end
        b1.up_data_i  = 32'hC;
        b1.flush_i    = 1'b1;
        b1.dn_ready_i = 1'b1;
        tick();
        b1.flush_i    = 1'b0;
        b1.up_valid_i = 1'b0;
        vectors++;
        if (b1.dn_valid_o !== 1'b0 || b1.occupancy_o !== 2'd0 || b1.up_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_empty got v=%0b occ=%0d rdy=%0b want v=0 occ=0 rdy=1",
                     b1.dn_valid_o, b1.occupancy_o, b1.up_ready_o);
        end
        vectors++;
        if (b1.stall_cnt_o !== 16'd1) begin errors++; $display("FAIL flush_stall got %0d want 1", b1.stall_cnt_o); end
        vectors++;
        if (b1.dn_data_o !== 32'hA) begin errors++; $display("FAIL flush_data_kept got %h want a", b1.dn_data_o); end
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if (b1.dn_valid_o !== 1'b0) begin errors++; $display("FAIL flush_no_c%0d got v=%0b want 0", k, b1.dn_valid_o); end
        end
        b1.up_valid_i = 1'b1;
        b1.up_data_i  = 32'hD;
        tick();
        b1.up_valid_i = 1'b0;
        vectors++;
        if (b1.dn_valid_o !== 1'b1 || b1.dn_data_o !== 32'hD) begin
            errors++;
            $display("FAIL flush_next got v=%0b d=%h want v=1 d=d", b1.dn_valid_o, b1.dn_data_o);
        end
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        b2.dn_ready_i = 1'b0;
        b2.up_valid_i = 1'b1;
        b2.up_data_i  = 32'h55;
        tick();
        b2.up_valid_i = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            logic [3:0] exp;
            tick();
            exp = (k >= 15) ? 4'hF : 4'(k);
            vectors++;
            if (b2.stall_cnt_o !== exp) begin
                errors++;
                $display("FAIL sat_cycle%0d got %h want %h", k, b2.stall_cnt_o, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] q[$];
        int          exp_stall;
        do_reset();
        exp_stall = 0;
        for (int c = 0; c < 10000; c++) begin
            b1.up_valid_i = 1'($urandom_range(0, 1));
            b1.dn_ready_i = ($urandom_range(0, 3) != 0);
            b1.up_data_i  = $urandom;
            vectors++;
            if (b1.dn_valid_o !== (q.size() > 0) || b1.up_ready_o !== (q.size() < 2) ||
                b1.occupancy_o !== 2'(q.size()) ||
                (q.size() > 0 && b1.dn_data_o !== q[0])) begin
                errors++;
                $display("FAIL rand_cycle%0d got v=%0b rdy=%0b occ=%0d d=%h want occ=%0d d=%h",
                         c, b1.dn_valid_o, b1.up_ready_o, b1.occupancy_o, b1.dn_data_o,
                         q.size(), (q.size() > 0) ? q[0] : 32'h0);
            end
            if (q.size() > 0 && !b1.dn_ready_i) exp_stall++;
            if (q.size() > 0 && b1.dn_ready_i) void'(q.pop_front());
            if (b1.up_valid_i && q.size() + ((q.size() == 0) ? 0 : 0) < 3 && b1.up_ready_o === 1'b1) begin
                if (!(q.size() == 2)) q.push_back(b1.up_data_i);
            end
            tick();
        end
        vectors++;
        if (b1.stall_cnt_o !== 16'(exp_stall)) begin
            errors++;
            $display("FAIL rand_stall got %0d want %0d", b1.stall_cnt_o, exp_stall);
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        rst_n   = 1'b0;
        b2.flush_i    = 1'b0;
        b2.up_valid_i = 1'b0;
        b2.up_data_i  = '0;
        b2.dn_ready_i = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule : tb_pipe_skid_stage
`default_nettype wire
